otter_fetch_ctrl: RTL and testbench
===================================

# otter_fetch_ctrl

Instruction-fetch control stage of the pipelined OTTER MCU. It sits directly downstream of the jump-target generator and branch resolution, and upstream of decode. It owns the program counter and selects the next PC from sequential, JAL, JALR or branch targets. It also runs the request/valid handshake with the instruction cache and loads the IF/ID pipeline register, with stall, flush and miss handling.

## Interface
- RESET_VEC, 32'h0000_0000, PC value loaded on reset.
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous, active-low reset.
- PC_SOURCE  in  2  redirect select from execute: 0 = none (PC+4), 1 = JALR, 2 = BRANCH, 3 = JAL.
- JAL  in  32  JAL target.
- JALR  in  32  JALR target.
- BRANCH  in  32  taken-branch target.
- STALL  in  1  hazard unit stall; IF/ID must hold.
- IC_REQ  out  1  fetch request to the instruction cache.
- IC_ADDR  out  32  fetch address; always equals PC.
- IC_VALID  in  1  cache returns data for IC_ADDR this cycle (hit in the same cycle, miss some cycles later).
- IC_DATA  in  32  instruction word, qualified by IC_VALID.
- IF_VALID  out  1  IF/ID entry holds a real instruction.
- IF_PC  out  32  PC of the IF/ID instruction.
- IF_IR  out  32  instruction in IF/ID.

## Operation
- Transfer: a fetch completes when IC_REQ & IC_VALID.
- Cache rule: once IC_REQ is high without IC_VALID, IC_REQ and IC_ADDR stay stable until IC_VALID arrives.
- Redirect: any nonzero PC_SOURCE is a redirect. The target is forced to bits[1:0] = 2'b00, which also clears the JALR LSB. Compressed instructions are not supported.
- Skid: a one-entry skid buffer {pc, ir} captures a fetch that completes while STALL is high.
- States: RUN and DROP.
- RUN, no redirect:
  - Skid full: IC_REQ = 0. If !STALL, IF/ID <= skid, IF_VALID <= 1, skid empties.
  - Skid empty: IC_REQ = 1.
    - On transfer with !STALL: IF/ID <= {PC, IC_DATA}, IF_VALID <= 1, PC <= PC+4.
    - On transfer with STALL: skid <= {PC, IC_DATA}, PC <= PC+4, IF/ID holds.
    - No transfer with !STALL: IF_VALID <= 0 (bubble).
    - No transfer with STALL: hold.
- RUN, redirect: IF_VALID <= 0 and skid empties. Flush beats STALL.
  - If a transfer occurs or IC_REQ = 0 this cycle: any returned data is discarded, PC <= target, stay RUN.
  - If a miss is outstanding: target is latched into a pending register and state goes to DROP. PC does not change, to keep IC_ADDR stable.
- DROP:
  - IC_REQ stays 1 and IF_VALID stays 0.
  - On IC_VALID: data is discarded, PC <= pending target, go to RUN.
  - A new redirect in DROP overwrites the pending target.
- Arithmetic: PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0); there is no trap.

## Timing
- Reset (asynchronous, immediate): PC = RESET_VEC, state RUN, skid empty, IF_VALID = 0, IF_PC = 0, IF_IR = 32'h0000_0013 (NOP).
- IC_REQ and IC_ADDR are combinational from registered state only, with no IN->OUT path from STALL or PC_SOURCE. On a redirect cycle the current request still completes against the old address.
- Hit latency: IF/ID updates at the edge ending the transfer cycle. Back-to-back hits give one instruction per cycle.
- Redirect penalty: the first target instruction is valid in IF/ID 2 cycles after the redirect cycle on hit. With DROP, the penalty is the remaining miss latency + 2.
- Reset asserted mid-miss abandons the request; the cache is reset by the same RST_N.

## Structure
- otter_pkg holds:
  - pc_src_t enum: PC_NEXT, PC_JALR, PC_BRANCH, PC_JAL.
  - fetch_state_t enum: RUN, DROP.
  - NOP_INSTR constant (32'h0000_0013).
- One natural sub-module: fetch_skid_buf, the 1-entry {pc, ir} holding register with valid flag.

## Test plan
- Reset release, always-hit cache, STALL = 0 -> IF_PC sequence 0x0, 0x4, 0x8 on consecutive cycles, IF_VALID high from cycle 1.
- Hit at PC 0x10 while STALL = 1 -> skid holds {0x10, data}, IC_REQ = 0. STALL drops -> IF_PC = 0x10 next cycle, then fetch resumes at 0x14.
- PC_SOURCE = 3 with JAL = 0x200 during a hit at 0x40 -> IF_VALID 0 for one cycle, then IF_PC = 0x200. The 0x40 data never reaches IF/ID.
- Miss outstanding at 0x80 (IC_VALID after 5 cycles) with PC_SOURCE = 1, JALR = 0x301 at cycle 1 -> IC_ADDR holds 0x80 until IC_VALID, that data is dropped, then the next fetch address is 0x300.
- Redirect with STALL = 1 and skid full -> skid flushed, IF_VALID = 0, next fetch at the target.
- PC = 0xFFFF_FFFC hit -> next IC_ADDR = 0x0000_0000. Assert RST_N = 0 mid-miss -> PC = RESET_VEC immediately and IF_IR = NOP.

Source files
------------

// File: rtl/otter_pkg.sv
// -----------------------------------------------------------------------------
// otter_pkg
// Shared types and constants for the OTTER instruction-fetch control stage.
//   pc_src_t      : redirect select coming from execute
//   fetch_state_t : fetch FSM states (RUN = normal fetch, DROP = discard the
//                   outstanding miss, then jump to the pending target)
//   NOP_INSTR     : addi x0,x0,0, placed in IF/ID on reset
//   word_align()  : forces a target onto a 4-byte boundary
// -----------------------------------------------------------------------------
package otter_pkg;

   typedef enum logic [1:0] {
      PC_NEXT   = 2'd0,
      PC_JALR   = 2'd1,
      PC_BRANCH = 2'd2,
      PC_JAL    = 2'd3
   } pc_src_t;

   typedef enum logic {
      RUN  = 1'b0,
      DROP = 1'b1
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // Compressed instructions are not supported, so every target is word
   // aligned; this also clears the JALR LSB.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// -----------------------------------------------------------------------------
// fetch_skid_buf
// One-entry {pc, ir} holding register used when a fetch completes while the
// IF/ID register is stalled.
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset
//   load_i   : capture pc_i/ir_i and mark the entry valid
//   clear_i  : empty the entry (drain into IF/ID or flush); wins over load_i
//   pc_i     : PC of the captured instruction
//   ir_i     : captured instruction word
//   valid_o  : entry holds an instruction
//   pc_o     : stored PC
//   ir_o     : stored instruction word
// -----------------------------------------------------------------------------
module fetch_skid_buf
   import otter_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        load_i,
   input  logic        clear_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] ir_i,
   output logic        valid_o,
   output logic [31:0] pc_o,
   output logic [31:0] ir_o
);

   logic        valid_q;
   logic [31:0] pc_q;
   logic [31:0] ir_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         pc_q    <= 32'h0000_0000;
         ir_q    <= NOP_INSTR;
      end else if (clear_i) begin
         valid_q <= 1'b0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         pc_q    <= pc_i;
         ir_q    <= ir_i;
      end
   end

   assign valid_o = valid_q;
   assign pc_o    = pc_q;
   assign ir_o    = ir_q;

endmodule

// File: rtl/otter_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// otter_fetch_ctrl
// Instruction-fetch control: owns the PC, selects the next PC, runs the
// request/valid handshake with the instruction cache and loads IF/ID.
//   CLK        : rising-edge clock
//   RST_N      : asynchronous active-low reset
//   PC_SOURCE  : redirect select (0 none, 1 JALR, 2 BRANCH, 3 JAL)
//   JAL/JALR/BRANCH : redirect targets
//   STALL      : IF/ID must hold
//   IC_REQ     : fetch request (from registered state only)
//   IC_ADDR    : fetch address, always the PC
//   IC_VALID   : cache returns IC_DATA for IC_ADDR this cycle
//   IC_DATA    : instruction word
//   IF_VALID   : IF/ID holds a real instruction
//   IF_PC      : PC of the IF/ID instruction
//   IF_IR      : IF/ID instruction word
// -----------------------------------------------------------------------------
module otter_fetch_ctrl
   import otter_pkg::*;
#(
   parameter logic [31:0] RESET_VEC = 32'h0000_0000
)(
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [1:0]  PC_SOURCE,
   input  logic [31:0] JAL,
   input  logic [31:0] JALR,
   input  logic [31:0] BRANCH,
   input  logic        STALL,
   output logic        IC_REQ,
   output logic [31:0] IC_ADDR,
   input  logic        IC_VALID,
   input  logic [31:0] IC_DATA,
   output logic        IF_VALID,
   output logic [31:0] IF_PC,
   output logic [31:0] IF_IR
);

   fetch_state_t state_q;
   logic [31:0]  pc_q;
   logic [31:0]  pend_q;
   logic         if_valid_q;
   logic [31:0]  if_pc_q;
   logic [31:0]  if_ir_q;

   pc_src_t      pc_src;
   logic         redirect;
   logic [31:0]  redir_tgt;
   logic [31:0]  pc_inc;
   logic         xfer;
   logic         miss_pending;

   logic         skid_valid;
   logic [31:0]  skid_pc;
   logic [31:0]  skid_ir;
   logic         skid_load;
   logic         skid_clear;

   assign pc_src   = pc_src_t'(PC_SOURCE);
   assign redirect = (pc_src != PC_NEXT);
   assign pc_inc   = pc_q + 32'd4;   // wraps modulo 2^32

   always_comb begin
      redir_tgt = 32'h0000_0000;
      case (pc_src)
         PC_JALR:   redir_tgt = word_align(JALR);
         PC_BRANCH: redir_tgt = word_align(BRANCH);
         PC_JAL:    redir_tgt = word_align(JAL);
         default:   redir_tgt = 32'h0000_0000;
      endcase
   end

   // Request depends only on registered state: while the skid holds an
   // instruction there is nowhere to put another, so fetch pauses.
   assign IC_REQ       = (state_q == DROP) || !skid_valid;
   assign IC_ADDR      = pc_q;
   assign xfer         = IC_REQ && IC_VALID;
   assign miss_pending = IC_REQ && !IC_VALID;

   // Skid captures a completing fetch only when IF/ID is stalled; a redirect
   // flushes it, and it drains as soon as the stall lifts.
   assign skid_load  = (state_q == RUN) && !redirect && !skid_valid && xfer && STALL;
   assign skid_clear = (state_q == RUN) && (redirect || (skid_valid && !STALL));

   fetch_skid_buf u_skid (
      .clk_i   (CLK),
      .rst_ni  (RST_N),
      .load_i  (skid_load),
      .clear_i (skid_clear),
      .pc_i    (pc_q),
      .ir_i    (IC_DATA),
      .valid_o (skid_valid),
      .pc_o    (skid_pc),
      .ir_o    (skid_ir)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= RUN;
         pc_q       <= RESET_VEC;
         pend_q     <= 32'h0000_0000;
         if_valid_q <= 1'b0;
         if_pc_q    <= 32'h0000_0000;
         if_ir_q    <= NOP_INSTR;
      end else begin
         case (state_q)
            RUN: begin
               if (redirect) begin
                  // Flush beats stall. With a miss outstanding the PC must
                  // stay put so the cache sees a stable address; park the
                  // target until the miss returns.
                  if_valid_q <= 1'b0;
                  if (miss_pending) begin
                     pend_q  <= redir_tgt;
                     state_q <= DROP;
                  end else begin
                     pc_q <= redir_tgt;
                  end
               end else if (skid_valid) begin
                  if (!STALL) begin
                     if_valid_q <= 1'b1;
                     if_pc_q    <= skid_pc;
                     if_ir_q    <= skid_ir;
                  end
               end else if (xfer) begin
                  pc_q <= pc_inc;
                  if (!STALL) begin
                     if_valid_q <= 1'b1;
                     if_pc_q    <= pc_q;
                     if_ir_q    <= IC_DATA;
                  end
               end else if (!STALL) begin
                  if_valid_q <= 1'b0;
               end
            end
            DROP: begin
               if_valid_q <= 1'b0;
               if (redirect) begin
                  pend_q <= redir_tgt;
               end
               if (IC_VALID) begin
                  // The newest redirect wins if it arrives with the data.
                  pc_q    <= redirect ? redir_tgt : pend_q;
                  state_q <= RUN;
               end
            end
            default: state_q <= RUN;
         endcase
      end
   end

   assign IF_VALID = if_valid_q;
   assign IF_PC    = if_pc_q;
   assign IF_IR    = if_ir_q;

endmodule

// File: tb/tb_otter_fetch_ctrl.sv
module tb_otter_fetch_ctrl;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam int NVEC = 31;

   logic        CLK;
   logic        RST_N;
   logic [1:0]  PC_SOURCE;
   logic [31:0] JAL, JALR, BRANCH;
   logic        STALL;
   logic        IC_REQ;
   logic [31:0] IC_ADDR;
   logic        IC_VALID;
   logic [31:0] IC_DATA;
   logic        IF_VALID;
   logic [31:0] IF_PC;
   logic [31:0] IF_IR;

   otter_fetch_ctrl #(.RESET_VEC(32'h0000_0000)) dut (
      .CLK(CLK), .RST_N(RST_N), .PC_SOURCE(PC_SOURCE),
      .JAL(JAL), .JALR(JALR), .BRANCH(BRANCH), .STALL(STALL),
      .IC_REQ(IC_REQ), .IC_ADDR(IC_ADDR), .IC_VALID(IC_VALID),
      .IC_DATA(IC_DATA), .IF_VALID(IF_VALID), .IF_PC(IF_PC), .IF_IR(IF_IR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic        stall;
      logic [1:0]  src;
      logic [31:0] tgt;
      logic        icv;
      logic [31:0] data;
      logic        req;    // expected IC_REQ before the edge
      logic [31:0] addr;   // expected IC_ADDR before the edge
      logic        v;      // expected IF_VALID after the edge
      logic [31:0] pc;     // expected IF_PC after the edge (checked when v)
      logic [31:0] ir;
   } vec_t;

   typedef struct {
      logic        v;
      logic [31:0] pc;
      logic [31:0] ir;
   } exp_t;

   vec_t tbl [NVEC];
   exp_t sb [$];
   int   pass_cnt = 0;
   int   total_cnt = 0;

   // Instruction word the "cache" returns for an address.
   function automatic logic [31:0] idata(input logic [31:0] a);
      return a ^ 32'h5A5A_0013;
   endfunction

   function automatic vec_t mk(input logic st, input logic [1:0] src, input logic [31:0] tgt,
                               input logic icv, input logic [31:0] daddr,
                               input logic req, input logic [31:0] addr,
                               input logic v, input logic [31:0] pc);
      vec_t r;
      r.stall = st; r.src = src; r.tgt = tgt; r.icv = icv; r.data = idata(daddr);
      r.req = req; r.addr = addr; r.v = v; r.pc = pc; r.ir = idata(pc);
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h", name, act, exp);
      else
         pass_cnt++;
   endtask

   task automatic drive(input logic st, input logic [1:0] src, input logic [31:0] tgt,
                        input logic icv, input logic [31:0] data);
      STALL     = st;
      PC_SOURCE = src;
      JALR      = (src == 2'd1) ? tgt : 32'hDEAD_BEE0;
      BRANCH    = (src == 2'd2) ? tgt : 32'hDEAD_BEE4;
      JAL       = (src == 2'd3) ? tgt : 32'hDEAD_BEE8;
      IC_VALID  = icv;
      IC_DATA   = data;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      exp_t e;
      // Sequential, bubble, stall/skid, JAL flush, miss+JALR DROP, redirect
      // with full skid, DROP overwrite, PC wrap.
      tbl[0]  = mk(0,0,0,          1,32'h0,       1,32'h0,       1,32'h0);
      tbl[1]  = mk(0,0,0,          1,32'h4,       1,32'h4,       1,32'h4);
      tbl[2]  = mk(0,0,0,          1,32'h8,       1,32'h8,       1,32'h8);
      tbl[3]  = mk(0,0,0,          0,32'h0,       1,32'hC,       0,32'h0);
      tbl[4]  = mk(0,0,0,          1,32'hC,       1,32'hC,       1,32'hC);
      tbl[5]  = mk(1,0,0,          1,32'h10,      1,32'h10,      1,32'hC);
      tbl[6]  = mk(1,0,0,          0,32'h0,       0,32'h14,      1,32'hC);
      tbl[7]  = mk(0,0,0,          0,32'h0,       0,32'h14,      1,32'h10);
      tbl[8]  = mk(0,0,0,          1,32'h14,      1,32'h14,      1,32'h14);
      tbl[9]  = mk(0,3,32'h40,     1,32'h18,      1,32'h18,      0,32'h0);
      tbl[10] = mk(0,3,32'h200,    1,32'h40,      1,32'h40,      0,32'h0);
      tbl[11] = mk(0,0,0,          1,32'h200,     1,32'h200,     1,32'h200);
      tbl[12] = mk(0,0,0,          1,32'h204,     1,32'h204,     1,32'h204);
      tbl[13] = mk(0,2,32'h80,     1,32'h208,     1,32'h208,     0,32'h0);
      tbl[14] = mk(0,1,32'h301,    0,32'h0,       1,32'h80,      0,32'h0);
      tbl[15] = mk(0,0,0,          0,32'h0,       1,32'h80,      0,32'h0);
      tbl[16] = mk(0,0,0,          0,32'h0,       1,32'h80,      0,32'h0);
      tbl[17] = mk(0,0,0,          0,32'h0,       1,32'h80,      0,32'h0);
      tbl[18] = mk(0,0,0,          1,32'h80,      1,32'h80,      0,32'h0);
      tbl[19] = mk(0,0,0,          1,32'h300,     1,32'h300,     1,32'h300);
      tbl[20] = mk(1,0,0,          1,32'h304,     1,32'h304,     1,32'h300);
      tbl[21] = mk(1,2,32'h500,    0,32'h0,       0,32'h308,     0,32'h0);
      tbl[22] = mk(0,0,0,          1,32'h500,     1,32'h500,     1,32'h500);
      tbl[23] = mk(0,3,32'h600,    0,32'h0,       1,32'h504,     0,32'h0);
      tbl[24] = mk(0,1,32'h700,    0,32'h0,       1,32'h504,     0,32'h0);
      tbl[25] = mk(0,0,0,          1,32'h504,     1,32'h504,     0,32'h0);
      tbl[26] = mk(0,0,0,          1,32'h700,     1,32'h700,     1,32'h700);
      tbl[27] = mk(0,3,32'hFFFF_FFFC,1,32'h704,   1,32'h704,     0,32'h0);
      tbl[28] = mk(0,0,0,          1,32'hFFFF_FFFC,1,32'hFFFF_FFFC,1,32'hFFFF_FFFC);
      tbl[29] = mk(0,0,0,          1,32'h0,       1,32'h0,       1,32'h0);
      tbl[30] = mk(0,0,0,          0,32'h0,       1,32'h4,       0,32'h0);

      RST_N = 1'b0;
      drive(0, 0, 0, 0, 32'h0);
      @(negedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
      #1;
      chk("reset_ic_req",   {31'd0, IC_REQ},   32'd1);
      chk("reset_ic_addr",  IC_ADDR,           32'h0);
      chk("reset_if_valid", {31'd0, IF_VALID}, 32'd0);
      chk("reset_if_pc",    IF_PC,             32'h0);
      chk("reset_if_ir",    IF_IR,             NOP);

      for (int i = 0; i < NVEC; i++) begin
         drive(tbl[i].stall, tbl[i].src, tbl[i].tgt, tbl[i].icv, tbl[i].data);
         #1;
         chk($sformatf("v%0d_ic_req", i),  {31'd0, IC_REQ}, {31'd0, tbl[i].req});
         chk($sformatf("v%0d_ic_addr", i), IC_ADDR, tbl[i].addr);
         e.v = tbl[i].v; e.pc = tbl[i].pc; e.ir = tbl[i].ir;
         sb.push_back(e);
         @(posedge CLK);
         #1;
         if (sb.size() == 0) begin
            chk($sformatf("v%0d_scoreboard_empty", i), 32'd0, 32'd1);
         end else begin
            e = sb.pop_front();
            chk($sformatf("v%0d_if_valid", i), {31'd0, IF_VALID}, {31'd0, e.v});
            if (e.v) begin
               chk($sformatf("v%0d_if_pc", i), IF_PC, e.pc);
               chk($sformatf("v%0d_if_ir", i), IF_IR, e.ir);
            end
         end
         @(negedge CLK);
      end

      // Miss outstanding at 0x4, redirect enters DROP, then reset mid-miss.
      drive(0, 3, 32'h900, 0, 32'h0);
      #1;
      chk("drop_entry_addr", IC_ADDR, 32'h4);
      @(posedge CLK);
      #1;
      chk("drop_req_held",  {31'd0, IC_REQ}, 32'd1);
      chk("drop_addr_held", IC_ADDR, 32'h4);
      drive(0, 0, 0, 0, 32'h0);
      #2;
      RST_N = 1'b0;
      #1;
      chk("midmiss_reset_addr",     IC_ADDR, 32'h0);
      chk("midmiss_reset_req",      {31'd0, IC_REQ}, 32'd1);
      chk("midmiss_reset_if_valid", {31'd0, IF_VALID}, 32'd0);
      chk("midmiss_reset_if_pc",    IF_PC, 32'h0);
      chk("midmiss_reset_if_ir",    IF_IR, NOP);
      @(negedge CLK);
      RST_N = 1'b1;
      drive(0, 0, 0, 1, idata(32'h0));
      @(posedge CLK);
      #1;
      chk("post_reset_if_pc", IF_PC, 32'h0);
      chk("post_reset_next_addr", IC_ADDR, 32'h4);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
